// File: rtl/piso_link_pkg.sv
// Shared definitions for the PISO readout link (transmitter and receiver capture).
package piso_link_pkg;

    localparam int LANES  = 10;
    localparam int WORD_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } link_state_e;

    // LSB position of word k inside a flat LANES*WORD_W frame bus.
    function automatic int word_base(input int k, input int w);
        return k * w;
    endfunction

endpackage

// File: rtl/piso_frame_tx_if.sv
// Frame request side and serial pin side of the PISO transmitter.
interface piso_frame_tx_if #(
    parameter int LANES  = piso_link_pkg::LANES,
    parameter int WORD_W = piso_link_pkg::WORD_W
);
    logic                      start;
    logic [LANES*WORD_W-1:0]   data_in;
    logic                      busy;
    logic                      done;
    logic                      load;
    logic                      shift_clk;
    logic [LANES-1:0]          q;

    modport master (
        output start, data_in,
        input  busy, done, load, shift_clk, q
    );

    modport slave (
        input  start, data_in,
        output busy, done, load, shift_clk, q
    );
endinterface

// File: rtl/shift_clk_div.sv
// Half-period divider: counts DIV cycles per phase, toggles the shift clock
// phase and strobes the end of each high phase. Held cleared when disabled.
module shift_clk_div #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic tick,
    output logic fall,
    output logic phase
);
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt_q;
    logic          phase_q;

    assign tick  = en && (cnt_q == CW'(DIV - 1));
    assign fall  = tick && phase_q;
    assign phase = phase_q;

    // Count within a half-period; flip phase at its last cycle.
    always_ff @(posedge clk) begin
        if (!rst_n || !en || clr) begin
            cnt_q   <= '0;
            phase_q <= 1'b0;
        end else if (tick) begin
            cnt_q   <= '0;
            phase_q <= ~phase_q;
        end else begin
            cnt_q   <= cnt_q + CW'(1);
        end
    end

endmodule

// File: rtl/piso_frame_tx.sv
// PISO link transmitter: latches one frame of LANES words, then shifts each
// word LSB first on its own lane with WORD_W rising edges of shift_clk.
module piso_frame_tx #(
    parameter int LANES  = piso_link_pkg::LANES,
    parameter int WORD_W = piso_link_pkg::WORD_W,
    parameter int DIV    = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    piso_frame_tx_if.slave link
);
    import piso_link_pkg::*;

    localparam int BW = (WORD_W > 1) ? $clog2(WORD_W) : 1;

    link_state_e                     state_q, state_d;
    logic [LANES-1:0][WORD_W-1:0]    shadow_q;
    logic [LANES-1:0][WORD_W-1:0]    data_lane;
    logic [BW-1:0]                   bit_cnt_q;
    logic [BW-1:0]                   nxt_idx;
    logic                            last_bit;
    logic [LANES-1:0]                lane_b0, lane_bn;
    logic                            busy_q, done_q, load_q;
    logic                            busy_d, done_d, load_d;
    logic [LANES-1:0]                q_q, q_d;
    logic                            div_en, div_clr, div_tick, div_fall, phase;

    assign div_en   = (state_q == ST_LOAD) || (state_q == ST_SHIFT);
    assign div_clr  = (state_d != state_q);
    assign last_bit = (bit_cnt_q == BW'(WORD_W - 1));
    assign nxt_idx  = bit_cnt_q + BW'(1);

    shift_clk_div #(.DIV(DIV)) u_div (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (div_en),
        .clr   (div_clr),
        .tick  (div_tick),
        .fall  (div_fall),
        .phase (phase)
    );

    // Per-lane word slicing and the bit each lane presents next.
    for (genvar k = 0; k < LANES; k++) begin : g_lane
        assign data_lane[k] = link.data_in[word_base(k, WORD_W) +: WORD_W];
        assign lane_b0[k]   = shadow_q[k][0];
        assign lane_bn[k]   = shadow_q[k][nxt_idx];
    end

    // State register plus registered outputs, all reset together.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            load_q  <= 1'b1;
            q_q     <= '0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            load_q  <= load_d;
            q_q     <= q_d;
        end
    end

    // Next state: LOAD for one half-period, SHIFT until the last high phase ends.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (link.start)            state_d = ST_LOAD;
            ST_LOAD:  if (div_tick)              state_d = ST_SHIFT;
            ST_SHIFT: if (div_fall && last_bit)  state_d = ST_DONE;
            ST_DONE:                             state_d = ST_IDLE;
            default:                             state_d = ST_IDLE;
        endcase
    end

    // Output values for the coming state; q only moves on SHIFT entry or a falling shift_clk.
    always_comb begin
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
        load_d = (state_d != ST_SHIFT);
        q_d    = '0;
        if (state_d == ST_SHIFT) begin
            if (state_q == ST_LOAD)
                q_d = lane_b0;
            else if (div_fall)
                q_d = lane_bn;
            else
                q_d = q_q;
        end
    end

    // Shadow copy of the frame, taken only when a request is accepted.
    always_ff @(posedge clk) begin
        if (!rst_n)
            shadow_q <= '0;
        else if (state_q == ST_IDLE && link.start)
            shadow_q <= data_lane;
    end

    // Bit index within the frame; advances at each high->low of shift_clk.
    always_ff @(posedge clk) begin
        if (!rst_n || state_q != ST_SHIFT)
            bit_cnt_q <= '0;
        else if (div_fall && !last_bit)
            bit_cnt_q <= bit_cnt_q + BW'(1);
    end

    assign link.busy      = busy_q;
    assign link.done      = done_q;
    assign link.load      = load_q;
    assign link.shift_clk = phase;
    assign link.q         = q_q;

endmodule

// File: doc/piso_frame_tx.md
# piso_frame_tx

Transmit side of the test-chip PISO readout link. Accepts one frame of ten 16-bit words, then drives `load`, `shift_clk` and ten serial lanes `q` so that a receiver sampling on rising `shift_clk` while `load` is low captures each word LSB first in exactly 16 edges. Used to emulate the test chip's error-count PISO on the FPGA and to drive chip-side SIPO inputs over the same pin protocol.

## Interface
- `LANES`, 10, number of serial lanes and words per frame
- `WORD_W`, 16, bits per word; also the number of `shift_clk` rising edges per frame
- `DIV`, 4, `clk` cycles per `shift_clk` half-period; legal range ≥1
- `clk`  in  1  system clock; all logic on its rising edge
- `rst_n`  in  1  synchronous active-low reset
- `start`  in  1  frame request, sampled in IDLE only
- `data_in`  in  LANES*WORD_W  word k in bits [k*WORD_W +: WORD_W], latched on accepted `start`
- `busy`  out  1  high from the cycle after `start` acceptance until the cycle after the `done` cycle
- `done`  out  1  one-cycle pulse at frame end
- `load`  out  1  high = idle or load phase; low = shifting
- `shift_clk`  out  1  registered divided clock toward the receiver
- `q`  out  LANES  lane k carries word k, LSB first

## Operation
- States: IDLE, LOAD, SHIFT, DONE.
- IDLE: `load`=1, `shift_clk`=0, `q`=0, `busy`=0. `start`=1 -> latch `data_in` into the shadow register, go to LOAD.
- LOAD: `load`=1, `shift_clk`=0 for DIV cycles -> SHIFT.
- SHIFT: `load`=0. Per bit i (0..WORD_W-1): `q[k]`=word k bit i for the whole bit period; `shift_clk` low DIV cycles, then high DIV cycles. After the high phase of bit WORD_W-1 -> DONE.
- `q` changes only on entry to SHIFT and at each high->low transition of `shift_clk`, never at a rising edge.
- DONE: one cycle, `done`=1, `load`=1, `shift_clk`=0, `q`=0 -> IDLE.
- Exactly WORD_W rising edges of `shift_clk` per frame, all with `load`=0; no rising edge ever occurs with `load`=1, keeping the receiver's modulo-16 bit counter aligned.
- `start` outside IDLE is ignored; no queuing. `data_in` changes after acceptance have no effect.
- A divider counter of ceil(log2(DIV)) bits and a bit counter of ceil(log2(WORD_W)) bits; both clear on state entry; no wrap beyond terminal count.
- Reset mid-frame: on the next edge all outputs return to IDLE values and the frame is aborted. The receiver is left misaligned by the number of edges already sent; re-aligning it is the system controller's responsibility.

## Timing
- Reset values: `load`=1, `shift_clk`=0, `q`=0, `busy`=0, `done`=0; state IDLE; counters 0.
- `start` high at edge T -> LOAD registered at T+1 (`busy`=1) -> `load` falls at T+1+DIV with bit 0 on `q`.
- Rising edge for bit i at T+1+DIV+(2i+1)·DIV; setup and hold of `q` around it are DIV cycles each.
- `done` at T+1+DIV+2·WORD_W·DIV; earliest next accepted `start` one cycle later, when IDLE is registered.
- Frame length: (2·WORD_W+1)·DIV+2 cycles from `start` edge to IDLE.
- All outputs registered; no combinational path from inputs to outputs.

## Structure
- Shared package `piso_link_pkg`: `LANES`, `WORD_W` defaults, the state enum, and the word-slice index helper. The receiver capture block uses the same package.
- Sub-module `shift_clk_div`: DIV counter producing the phase toggle and a falling-edge strobe; enabled only in LOAD/SHIFT and cleared otherwise.

## Test plan
- Reset then idle 20 cycles -> `load`=1, `shift_clk`=0, `q`=0, `busy`=0, `done` never pulses.
- DIV=2; words k=0..9 = 16'hA5C3+k; `start` -> loopback receiver model returns the same ten words; exactly 16 rising edges; `done` at T+1+2+64.
- Walking-one per lane (word k = 1<<k) with DIV=1 -> correct bit position per lane; `q` stable at every rising edge.
- `start` held high through the frame, `data_in` changed mid-frame -> one frame only, original data sent; second frame starts the cycle after returning to IDLE.
- Back-to-back frames 16'hFFFF then 16'h0000 on all lanes -> receiver counter aligned, both frames correct.
- `rst_n` low after bit 5 -> next edge outputs at reset values; a fresh frame after reset transmits correctly (receiver model reset alongside).
